// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from an upstream synchronous FIFO and sends each
// one as an asynchronous serial frame: start bit, WIDTH data bits LSB-first,
// an optional even-parity bit, then STOP_BITS stop bits.
//
// FIFO handshake: a byte is taken by a single-cycle fifo_rd_en_o pulse that is
// raised only after fifo_empty_i=0 was seen in IDLE. The FIFO presents the
// byte on fifo_rdata_i the following cycle (LOAD), where it is captured.
//
// Ports:
//   clk_i         clock, all state changes on its rising edge
//   rst_i         asynchronous active-high reset
//   enable_i      1 allows new frames to start (never aborts a frame)
//   fifo_empty_i  upstream FIFO empty flag (only looked at in IDLE)
//   fifo_rdata_i  upstream FIFO read data
//   fifo_rd_en_o  FIFO read strobe, one cycle per byte
//   tx_o          serial line, idle high
//   busy_o        1 whenever a frame is in progress
//   done_o        one-cycle pulse in the first IDLE cycle after a frame
//   frame_cnt_o   completed frame count, wraps at 16 bits
//   dbg_state     current FSM state encoding
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      frame_cnt_o,
  output logic [2:0]       dbg_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q;
  logic [BIT_W-1:0]   bit_q;
  logic [WIDTH-1:0]   shift_q;
  logic               parity_q;
  logic               done_q;
  logic [15:0]        cnt_q;
  logic               baud_wrap;

  // Bit boundaries happen only when the baud counter wraps.
  assign baud_wrap = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs; outputs depend on registered state only.
  always_comb begin
    state_d      = state_q;
    fifo_rd_en_o = 1'b0;
    tx_o         = 1'b1;
    busy_o       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (enable_i && !fifo_empty_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        fifo_rd_en_o = 1'b1;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_START;
      end
      S_START: begin
        tx_o = 1'b0;
        if (baud_wrap) state_d = S_DATA;
      end
      S_DATA: begin
        tx_o = shift_q[0];
        if (baud_wrap && (bit_q == DATA_LAST)) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_o = parity_q;
        if (baud_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        // bit_q counts stop bits here so two stop bits need no extra state.
        if (baud_wrap && (bit_q == STOP_LAST)) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q == S_IDLE) || (state_q == S_FETCH) || (state_q == S_LOAD)) begin
        baud_q <= '0;
      end else if (baud_wrap) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + BAUD_W'(1);
      end
      case (state_q)
        S_LOAD: begin
          shift_q  <= fifo_rdata_i;
          parity_q <= ^fifo_rdata_i;
          bit_q    <= '0;
        end
        S_DATA: begin
          if (baud_wrap) begin
            shift_q <= shift_q >> 1;
            bit_q   <= (bit_q == DATA_LAST) ? '0 : bit_q + BIT_W'(1);
          end
        end
        S_STOP: begin
          if (baud_wrap) begin
            if (bit_q == STOP_LAST) begin
              bit_q  <= '0;
              done_q <= 1'b1;
              cnt_q  <= cnt_q + 16'd1;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done_o      = done_q;
  assign frame_cnt_o = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. Instance 0: 8N1, instance 1: 8 bits, even parity,
// two stop bits; both at 4 clocks per bit. Each instance has its own FIFO
// responder; a frame-level model predicts all outputs every cycle.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int NB = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       en, emp, rd, tx, busy, done;
  logic [1:0][7:0]  rdata;
  logic [1:0][15:0] cnt;
  logic [1:0][2:0]  dbg;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) u_plain (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .fifo_empty_i(emp[0]),
    .fifo_rdata_i(rdata[0]), .fifo_rd_en_o(rd[0]), .tx_o(tx[0]), .busy_o(busy[0]),
    .done_o(done[0]), .frame_cnt_o(cnt[0]), .dbg_state(dbg[0]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) u_par (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .fifo_empty_i(emp[1]),
    .fifo_rdata_i(rdata[1]), .fifo_rd_en_o(rd[1]), .tx_o(tx[1]), .busy_o(busy[1]),
    .done_o(done[1]), .frame_cnt_o(cnt[1]), .dbg_state(dbg[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- upstream FIFO responders ----------------
  logic [7:0] fq0[$], fq1[$];
  logic [7:0] mq0[$], mq1[$];

  task automatic push_byte(input int i, input logic [7:0] b);
    if (i == 0) begin fq0.push_back(b); mq0.push_back(b); end
    else        begin fq1.push_back(b); mq1.push_back(b); end
  endtask

  initial forever begin
    @(negedge clk);
    if (rd[0] && fq0.size() > 0) rdata[0] = fq0.pop_front();
    if (rd[1] && fq1.size() > 0) rdata[1] = fq1.pop_front();
    emp[0] = (fq0.size() == 0);
    emp[1] = (fq1.size() == 0);
  end

  // ---------------- frame-level model ----------------
  // A frame is a timeline t counted from the fetch cycle: t=0 read strobe,
  // t=1 data arrives, t>=2 serial bits of C cycles each; after the last
  // bit comes one IDLE cycle flagged by done.
  bit [1:0]      m_busy, m_done;
  int            m_t[2], m_len[2];
  logic [15:0]   m_cnt[2];
  bit [NB-1:0]   m_bits[2];

  function automatic bit [NB-1:0] frame_bits(input logic [7:0] b, input int pen);
    bit [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1 + k] = b[k];
    if (pen != 0) f[9] = ^b;
    return f;
  endfunction

  initial begin
    m_cnt[0] = '0;
    m_cnt[1] = '0;
    forever begin
      @(posedge clk or posedge rst);
      // instance i uses parity = i and stop bits = i + 1
      for (int i = 0; i < 2; i++) begin
        logic [7:0] b;
        if (rst) begin
          m_busy[i] = 1'b0; m_done[i] = 1'b0; m_t[i] = 0; m_cnt[i] = '0;
        end else begin
          m_done[i] = 1'b0;
          if (m_busy[i]) begin
            m_t[i]++;
            if (m_t[i] == 2 + m_len[i]) begin
              m_busy[i] = 1'b0; m_done[i] = 1'b1; m_cnt[i] = m_cnt[i] + 16'd1;
            end
          end else if (en[i] && !emp[i]) begin
            b = '0;
            if (i == 0 && mq0.size() > 0) b = mq0.pop_front();
            if (i == 1 && mq1.size() > 0) b = mq1.pop_front();
            m_busy[i] = 1'b1;
            m_t[i]    = 0;
            m_bits[i] = frame_bits(b, i);
            m_len[i]  = (1 + 8 + i + (i + 1)) * C;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        logic e_tx;
        e_tx = (m_busy[i] && m_t[i] >= 2) ? m_bits[i][(m_t[i] - 2) / C] : 1'b1;
        chk($sformatf("u%0d_tx@%0t", i, $time), tx[i], e_tx);
        chk($sformatf("u%0d_busy@%0t", i, $time), busy[i], m_busy[i]);
        chk($sformatf("u%0d_rd@%0t", i, $time), rd[i], m_busy[i] && m_t[i] == 0);
        chk($sformatf("u%0d_done@%0t", i, $time), done[i], m_done[i]);
        chk($sformatf("u%0d_cnt@%0t", i, $time), cnt[i], m_cnt[i]);
      end
    end
  end

  // ---------------- event logs (sample indices) ----------------
  int rd_log0[$], done_log0[$], st_log0[$];
  int rd_log1[$], done_log1[$], st_log1[$];
  bit txh0[$], txh1[$];
  bit [1:0] armed;
  int busy_n0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rd[0]) begin rd_log0.push_back(txh0.size()); armed[0] = 1'b1; end
      if (done[0]) done_log0.push_back(txh0.size());
      if (armed[0] && !tx[0]) begin st_log0.push_back(txh0.size()); armed[0] = 1'b0; end
      txh0.push_back(tx[0]);
      if (busy[0]) busy_n0++;
      if (rd[1]) begin rd_log1.push_back(txh1.size()); armed[1] = 1'b1; end
      if (done[1]) done_log1.push_back(txh1.size());
      if (armed[1] && !tx[1]) begin st_log1.push_back(txh1.size()); armed[1] = 1'b0; end
      txh1.push_back(tx[1]);
    end
  end

  task automatic clear_logs();
    rd_log0.delete(); done_log0.delete(); st_log0.delete(); txh0.delete();
    rd_log1.delete(); done_log1.delete(); st_log1.delete(); txh1.delete();
    armed   = '0;
    busy_n0 = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    en  = '0;
    fq0.delete(); fq1.delete(); mq0.delete(); mq1.delete();
    emp = 2'b11;
    @(negedge clk); #1;
    chk("rst_tx", tx, 2'b11);
    chk("rst_busy", busy, 2'b00);
    chk("rst_rd", rd, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_cnt0", cnt[0], 16'd0);
    chk("rst_cnt1", cnt[1], 16'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_done(input int i, input int n, input int budget, input string tag);
    int got;
    got = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      got = (i == 0) ? done_log0.size() : done_log1.size();
      if (got >= n) break;
    end
    chk({tag, "_done_wait"}, got, n);
  endtask

  task automatic wait_start(input int i, input int budget, input string tag);
    int got;
    got = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      got = (i == 0) ? st_log0.size() : st_log1.size();
      if (got >= 1) break;
    end
    chk({tag, "_start_wait"}, got, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [63:0] wave;
    int st;
    en    = '0;
    emp   = 2'b11;
    rdata = '0;
    do_reset();
    chk_on = 1'b1;

    // 0xA5 on 8N1
    do_reset();
    push_byte(0, 8'hA5);
    en = 2'b01;
    wait_done(0, 1, 200, "a5");
    repeat (5) @(negedge clk);
    #1;
    chk("a5_rd_pulses", rd_log0.size(), 1);
    chk("a5_done_pulses", done_log0.size(), 1);
    chk("a5_frame_cnt", cnt[0], 16'd1);
    if (st_log0.size() == 1 && rd_log0.size() == 1 && done_log0.size() == 1) begin
      st = st_log0[0];
      chk("a5_fetch_to_start", st - rd_log0[0], 2);
      chk("a5_done_pos", done_log0[0] - st, 40);
      wave = '0;
      for (int k = 0; k < 40; k++) wave = {wave[62:0], 1'(txh0[st + k])};
      chk("a5_wave", wave, 64'h0F0F00F0FF);
    end

    // empty FIFO with enable held high
    do_reset();
    en = 2'b11;
    repeat (100) @(negedge clk);
    #1;
    chk("empty_rd0", rd_log0.size(), 0);
    chk("empty_rd1", rd_log1.size(), 0);
    chk("empty_busy", busy_n0, 0);
    chk("empty_tx", tx, 2'b11);

    // three queued bytes back to back
    do_reset();
    push_byte(0, 8'h00);
    push_byte(0, 8'hFF);
    push_byte(0, 8'h3C);
    en = 2'b01;
    wait_done(0, 3, 400, "b2b");
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_rd_pulses", rd_log0.size(), 3);
    chk("b2b_frame_cnt", cnt[0], 16'd3);
    if (rd_log0.size() == 3 && done_log0.size() == 3 && st_log0.size() == 3) begin
      chk("b2b_rd_after_done1", rd_log0[1] - done_log0[0], 1);
      chk("b2b_rd_after_done2", rd_log0[2] - done_log0[1], 1);
      chk("b2b_start_gap1", st_log0[1] - st_log0[0], 43);
      chk("b2b_start_gap2", st_log0[2] - st_log0[1], 43);
    end

    // 0x07 with even parity and two stop bits
    do_reset();
    push_byte(1, 8'h07);
    en = 2'b10;
    wait_done(1, 1, 200, "par");
    repeat (3) @(negedge clk);
    #1;
    chk("par_rd_pulses", rd_log1.size(), 1);
    chk("par_frame_cnt", cnt[1], 16'd1);
    if (st_log1.size() == 1 && done_log1.size() == 1) begin
      st = st_log1[0];
      chk("par_frame_len", done_log1[0] - st, 48);
      chk("par_parity_bit", 1'(txh1[st + 36]), 1'b1);
      wave = '0;
      for (int k = 0; k < 48; k++) wave = {wave[62:0], 1'(txh1[st + k])};
      chk("par_wave", wave, 64'h0FFF00000FFF);
    end

    // asynchronous reset in the middle of data bit 3
    do_reset();
    push_byte(0, 8'hA5);
    en = 2'b01;
    wait_start(0, 20, "rst");
    repeat (17) @(negedge clk);
    @(posedge clk);
    #2;
    chk("rst_mid_tx_before", tx[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx[0], 1'b1);
    chk("rst_mid_busy", busy[0], 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("rst_mid_no_reread", rd_log0.size(), 1);
    chk("rst_mid_no_done", done_log0.size(), 0);
    chk("rst_mid_cnt", cnt[0], 16'd0);

    // enable dropped during the start bit
    do_reset();
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    en = 2'b01;
    wait_start(0, 20, "en");
    en = 2'b00;
    repeat (120) @(negedge clk);
    #1;
    chk("en_drop_done", done_log0.size(), 1);
    chk("en_drop_rd", rd_log0.size(), 1);
    chk("en_drop_cnt", cnt[0], 16'd1);
    en = 2'b01;
    wait_done(0, 2, 200, "en_resume");
    #1;
    chk("en_resume_rd", rd_log0.size(), 2);
    chk("en_resume_cnt", cnt[0], 16'd2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
